// File: rtl/onewire_txn_sequencer.sv
// 1-Wire single-drop transaction sequencer: reset/presence, Skip ROM, one command byte, optional N-byte read.
// States: IDLE -> RST_LOW -> RST_REL -> WR_BIT -> RD_BIT -> FIN -> IDLE; one up-counter times every phase.
module onewire_txn_sequencer #(
  parameter int T_RSTL = 480,
  parameter int T_RSTH = 480,
  parameter int T_PDS  = 70,
  parameter int T_SLOT = 71,
  parameter int T_LOW0 = 60,
  parameter int T_LOW1 = 6,
  parameter int T_RDS  = 15,
  parameter int MAX_RD = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] cmd_i,
  input  logic [3:0] rd_len_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       no_presence_o,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  output logic       bus_pull_o,
  input  logic       bus_in_i
);

  localparam int          CW       = 10;
  localparam logic [7:0]  SKIP_ROM = 8'hCC;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_LOW = 3'd1,
    RST_REL = 3'd2,
    WR_BIT  = 3'd3,
    RD_BIT  = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [3:0]      byte_q, byte_d;
  logic            wbyte_q, wbyte_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [3:0]      len_q, len_d;
  logic            pres_q, pres_d;
  logic            nopres_q, nopres_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            meta_q, sync_q;
  logic            wr_bit;
  logic            slot_end;

  // Idle bus is high, so the synchroniser resets to 1 to avoid a false presence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= bus_in_i;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      wbyte_q    <= 1'b0;
      cmd_q      <= '0;
      len_q      <= '0;
      pres_q     <= 1'b0;
      nopres_q   <= 1'b0;
      sh_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      wbyte_q    <= wbyte_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      pres_q     <= pres_d;
      nopres_q   <= nopres_d;
      sh_q       <= sh_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    wbyte_d    = wbyte_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    pres_d     = pres_q;
    nopres_d   = nopres_q;
    sh_d       = sh_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    bus_pull_o = 1'b0;
    wr_bit     = wbyte_q ? cmd_q[bit_q] : SKIP_ROM[bit_q];
    slot_end   = (cnt_q == CW'(T_SLOT - 1));

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RST_LOW;
          cmd_d    = cmd_i;
          len_d    = (rd_len_i > 4'(MAX_RD)) ? 4'(MAX_RD) : rd_len_i;
          nopres_d = 1'b0;
          pres_d   = 1'b0;
          cnt_d    = '0;
        end
      end
      RST_LOW: begin
        bus_pull_o = 1'b1;
        if (cnt_q == CW'(T_RSTL - 1)) begin
          cnt_d   = '0;
          state_d = RST_REL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RST_REL: begin
        if (cnt_q == CW'(T_PDS)) pres_d = ~sync_q;
        if (cnt_q == CW'(T_RSTH - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          wbyte_d = 1'b0;
          if (pres_q) begin
            state_d = WR_BIT;
          end else begin
            state_d  = FIN;
            nopres_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR_BIT: begin
        bus_pull_o = (cnt_q < (wr_bit ? CW'(T_LOW1) : CW'(T_LOW0)));
        if (slot_end) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (wbyte_q) begin
              bit_d   = '0;
              byte_d  = '0;
              state_d = (len_q != 4'd0) ? RD_BIT : FIN;
            end else begin
              wbyte_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RD_BIT: begin
        bus_pull_o = (cnt_q < CW'(T_LOW1));
        if (cnt_q == CW'(T_RDS)) sh_d = {sync_q, sh_q[7:1]};
        if (slot_end) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rd_data_d  = sh_q;
            rd_valid_d = 1'b1;
            if (byte_q == len_q - 4'd1) state_d = FIN;
            else byte_d = byte_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o        = (state_q != IDLE) && (state_q != FIN);
  assign done_o        = (state_q == FIN);
  assign no_presence_o = nopres_q;
  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;

endmodule
